sram_mc_arbiter: RTL and testbench
==================================

# sram_mc_arbiter

Parametrised N-channel arbiter and timing controller for the board's asynchronous 16-bit SRAM. It lets several on-chip masters share the single SRAM device without going through the Nios interconnect. Typical masters are the JPEG decode output writer, the pixel fetch for the VGA path and a flash-to-SRAM loader. Round-robin arbitration, per-channel read-return strobes and a configurable read wait count replace the previous single-master SRAM external interface.

## Interface
Parameters:
- `NCH`, 4: number of requesting channels, 2..8.
- `AW`, 20: SRAM word-address width.
- `DW`, 16: SRAM data width; `DW/8` byte enables.
- `RD_WAIT`, 1: extra read wait cycles, 0..7.

Ports (channel buses flattened, channel i occupies slice i):
- `clk_clk` in 1: single clock; every register updates on the rising edge.
- `reset_reset` in 1: synchronous, active-high reset.
- `req` in NCH: per-channel request level.
- `we` in NCH: 1 = write, 0 = read.
- `addr` in NCH*AW: word address.
- `wdata` in NCH*DW: write data.
- `be` in NCH*DW/8: byte enables; bit 0 = low byte.
- `gnt` out NCH: one-cycle acceptance pulse.
- `rvalid` out NCH: one-cycle read-data strobe.
- `rdata` out DW: read data, shared by all channels, qualified by `rvalid`.
- `busy` out 1: high whenever the controller is not in IDLE.
- `SRAM_ADDR` out AW: SRAM address pins.
- `SRAM_DQ` inout DW: SRAM data pins.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: active-low SRAM controls, all registered.

## Operation
- Requester contract: a master raises `req[i]` and holds `we`, `addr`, `wdata` and `be` stable until `gnt[i]`. It may drop or keep `req[i]` the cycle after `gnt[i]`; holding it means a new request.
- State machine: IDLE, RD, WR1, WR2.
- IDLE:
  - All SRAM controls are high and DQ is hi-Z.
  - If any `req` is set, select the winner, pulse `gnt[winner]`, and capture the winner's command, channel index and byte enables.
  - Go to RD or WR1.
- Winner selection: round-robin. Search starts at `last+1` modulo NCH. `last` resets to NCH-1, so channel 0 wins first after reset.
- RD: lasts RD_WAIT+1 cycles.
  - `CE_N`=0, `OE_N`=0, UB/LB = ~be, address driven, DQ hi-Z.
  - On the final RD cycle, `SRAM_DQ` is registered into `rdata`.
  - The next cycle, which is IDLE, pulses `rvalid[ch]`.
- WR1: `CE_N`=0, `WE_N`=0, UB/LB = ~be, DQ driven with wdata.
- WR2: `WE_N`=1 while address and DQ are held for one hold cycle, then go to IDLE.
- `be`==0: the bus cycle still runs with UB_N=LB_N=1. Memory is unchanged. Read returns undefined data with `rvalid` still pulsed.
- Simultaneous events: a new grant may be issued in the same IDLE cycle that carries the previous read's `rvalid`.
- Reset mid-operation: the controller returns to IDLE on the next edge. Any pending `rvalid` is dropped and the RR pointer is restored.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `busy`=0, `SRAM_ADDR`=0, all `*_N`=1, DQ hi-Z.
- Read latency: `gnt` at cycle T, `rvalid` at T+RD_WAIT+2.
- Read issue rate: one read per RD_WAIT+2 cycles.
- Write: occupies 3 cycles (IDLE, WR1, WR2). WE_N is low for exactly one cycle.
- DQ turnaround: DQ is never driven in RD or in IDLE.
- `busy` is high in RD, WR1 and WR2.
- Arbiter fairness: with all NCH requesting continuously, each channel is granted once per NCH grants.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: arbitration is fixed priority, lowest index wins, and the `last` pointer is not built.
- Not defined: round-robin as described in Operation.
- All timing is identical in both modes.

## Test plan
- Single write then read, NCH=4, RD_WAIT=1:
  - Stimulus: ch2 writes 0x00123 ← 0xBEEF with be=11, then ch2 reads 0x00123.
  - Required: WE_N low for exactly 1 cycle, `rvalid[2]` 3 cycles after the read `gnt`, `rdata`=0xBEEF.
- Byte enable: write 0xBEEF, then write 0x1234 with be=01, then read.
  - Required: `rdata`=0xBE34 and UB_N=1 during the second write.
- Round-robin: all four channels hold `req` permanently with reads.
  - Required: grant order 0,1,2,3,0,1 with one grant every 3 cycles.
  - With `SRAM_ARB_FIXED_PRIO_EN` defined: only ch0 is granted.
- RD_WAIT=3: read `gnt` to `rvalid` = 5 cycles, and OE_N low for 4 cycles.
- Reset mid-read: assert `reset_reset` in the first RD cycle.
  - Required: no `rvalid` pulse, all controls high next cycle, and the next grant goes to ch0.
- Back-to-back: read on ch1 followed immediately by write on ch3.
  - Required: DQ is hi-Z in the IDLE cycle carrying `rvalid[1]`, and driven only in WR1 and WR2.

Source files
------------

// File: rtl/sram_mc_arbiter_if.sv
// Channel-side bus of the shared SRAM arbiter. Channel i occupies slice i of
// every flattened vector. The master modport is the requesting side, the
// slave modport is the arbiter.
interface sram_mc_arbiter_if #(
    parameter int NCH = 4,
    parameter int AW  = 20,
    parameter int DW  = 16
);
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        we;
    logic [NCH*AW-1:0]     addr;
    logic [NCH*DW-1:0]     wdata;
    logic [NCH*DW/8-1:0]   be;
    logic [NCH-1:0]        gnt;
    logic [NCH-1:0]        rvalid;
    logic [DW-1:0]         rdata;
    logic                  busy;

    modport master (output req, we, addr, wdata, be,
                    input  gnt, rvalid, rdata, busy);
    modport slave  (input  req, we, addr, wdata, be,
                    output gnt, rvalid, rdata, busy);
endinterface

// File: rtl/sram_mc_arbiter.sv
// N-channel arbiter and bus-cycle sequencer for the board's asynchronous
// 16-bit SRAM. Round-robin by default; defining SRAM_ARB_FIXED_PRIO_EN
// switches to fixed priority (lowest index wins) and removes the last-winner
// pointer. Bus timing is identical in both modes.
//
// state | meaning
// IDLE  | controls high, DQ released; grant is issued here when any req is up
// RD    | CE_N/OE_N low for RD_WAIT+1 cycles, DQ sampled on the last one
// WR1   | CE_N/WE_N low, DQ driven with write data
// WR2   | WE_N back high, address and DQ held one more cycle
module sram_mc_arbiter #(
    parameter int NCH     = 4,
    parameter int AW      = 20,
    parameter int DW      = 16,
    parameter int RD_WAIT = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    sram_mc_arbiter_if.slave    bus,
    output logic [AW-1:0]       SRAM_ADDR,
    inout  wire  [DW-1:0]       SRAM_DQ,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR1, S_WR2} state_t;

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [CW-1:0]   r_ch;
    logic [NCH-1:0]  r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   r_dq_out;
    logic            r_dq_oe;
    logic [AW-1:0]   r_sram_addr;
    logic            r_ce_n;
    logic            r_oe_n;
    logic            r_we_n;
    logic            r_ub_n;
    logic            r_lb_n;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic [CW-1:0]   r_last;
`endif

    logic            w_any;
    logic [CW-1:0]   w_win;
    logic [NCH-1:0]  w_gnt;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic [BW-1:0]   w_be;

    // Winner selection; later loop iterations override earlier ones, so the
    // loops run from lowest to highest priority.
    always_comb begin
        w_any = |bus.req;
        w_win = '0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bus.req[k]) w_win = CW'(k);
        end
`else
        for (int k = NCH; k >= 1; k--) begin
            if (bus.req[(int'(r_last) + k) % NCH]) w_win = CW'((int'(r_last) + k) % NCH);
        end
`endif
    end

    assign w_we    = bus.we[w_win];
    assign w_addr  = bus.addr[int'(w_win)*AW +: AW];
    assign w_wdata = bus.wdata[int'(w_win)*DW +: DW];
    assign w_be    = bus.be[int'(w_win)*BW +: BW];

    // Grant is visible in the IDLE cycle that accepts the command, so a
    // master can drop its request on the very next edge.
    always_comb begin
        w_gnt = '0;
        if (r_state == S_IDLE && w_any) w_gnt[w_win] = 1'b1;
    end

    assign bus.gnt    = w_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign bus.busy   = (r_state != S_IDLE);

    assign SRAM_ADDR  = r_sram_addr;
    assign SRAM_CE_N  = r_ce_n;
    assign SRAM_OE_N  = r_oe_n;
    assign SRAM_WE_N  = r_we_n;
    assign SRAM_UB_N  = r_ub_n;
    assign SRAM_LB_N  = r_lb_n;
    assign SRAM_DQ    = r_dq_oe ? r_dq_out : {DW{1'bz}};

    // Bus-cycle state machine; every SRAM pin is set from here for the next cycle.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ch        <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            r_last      <= CW'(NCH - 1);
`endif
        end else begin
            r_rvalid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ch        <= w_win;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                        r_last      <= w_win;
`endif
                        r_sram_addr <= w_addr;
                        r_ce_n      <= 1'b0;
                        r_ub_n      <= ~w_be[1];
                        r_lb_n      <= ~w_be[0];
                        if (w_we) begin
                            r_state  <= S_WR1;
                            r_we_n   <= 1'b0;
                            r_oe_n   <= 1'b1;
                            r_dq_oe  <= 1'b1;
                            r_dq_out <= w_wdata;
                        end else begin
                            r_state  <= S_RD;
                            r_oe_n   <= 1'b0;
                            r_cnt    <= 3'(RD_WAIT);
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt == 3'd0) begin
                        r_rdata        <= SRAM_DQ;
                        r_rvalid[r_ch] <= 1'b1;
                        r_state        <= S_IDLE;
                        r_ce_n         <= 1'b1;
                        r_oe_n         <= 1'b1;
                        r_ub_n         <= 1'b1;
                        r_lb_n         <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_WR1: begin
                    r_we_n  <= 1'b1;
                    r_state <= S_WR2;
                end
                S_WR2: begin
                    r_state <= S_IDLE;
                    r_ce_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mc_arbiter.sv
// Directed bench for sram_mc_arbiter: main instance with RD_WAIT=1 on a small
// SRAM model, second instance with RD_WAIT=3 on a fixed-pattern SRAM.
module tb_sram_mc_arbiter;
    localparam int NCH = 4;
    localparam int AW  = 20;
    localparam int DW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sram_mc_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus0 ();
    sram_mc_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus1 ();

    wire  [15:0] dq0;
    wire  [15:0] dq1;
    logic [19:0] a0, a1;
    logic ce0, oe0, we0, ub0, lb0;
    logic ce1, oe1, we1, ub1, lb1;
    logic probe = 1'b0;

    sram_mc_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_WAIT(1)) u_dut0 (
        .clk_clk(clk), .reset_reset(rst), .bus(bus0),
        .SRAM_ADDR(a0), .SRAM_DQ(dq0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0),
        .SRAM_WE_N(we0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0));

    sram_mc_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_WAIT(3)) u_dut1 (
        .clk_clk(clk), .reset_reset(rst), .bus(bus1),
        .SRAM_ADDR(a1), .SRAM_DQ(dq1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1),
        .SRAM_WE_N(we1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1));

    // SRAM model for instance 0 (256 words, byte-lane writes while WE_N low)
    logic [15:0] mem [0:255];
    assign dq0 = (!ce0 && !oe0 && we0) ? mem[a0[7:0]] : 16'hzzzz;
    always @(negedge clk) begin
        if (!ce0 && !we0) begin
            if (!lb0) mem[a0[7:0]][7:0]  <= dq0[7:0];
            if (!ub0) mem[a0[7:0]][15:8] <= dq0[15:8];
        end
    end
    // Known value put on the released bus; any DUT drive shows up as a change.
    assign dq0 = probe ? 16'h0000 : 16'hzzzz;
    assign dq1 = (!ce1 && !oe1) ? 16'hC0DE : 16'hzzzz;

    int we0_low = 0;
    int oe1_low = 0;
    always @(negedge clk) begin
        if (!we0) we0_low <= we0_low + 1;
        if (!oe1) oe1_low <= oe1_low + 1;
    end

    logic [3:0]  rv_ch  [64];
    logic [15:0] rv_dat [64];
    int          rv_cyc [64];
    int          rv_n = 0;
    always @(negedge clk) begin
        if (bus0.rvalid != 4'b0 && rv_n < 64) begin
            rv_ch[rv_n]  <= bus0.rvalid;
            rv_dat[rv_n] <= bus0.rdata;
            rv_cyc[rv_n] <= cyc;
            rv_n         <= rv_n + 1;
        end
    end

    typedef struct {
        int          ch;
        logic [15:0] data;
        bit          chk;
        int          due;
    } exp_t;
    exp_t sb[$];
    int   rd_idx = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int ch, input bit w, input logic [19:0] a,
                         input logic [15:0] d, input logic [1:0] b, output int gcyc);
        bit seen;
        seen = 1'b0;
        gcyc = -1;
        @(posedge clk); #1;
        bus0.req[ch] = 1'b1;
        bus0.we[ch]  = w;
        bus0.addr[ch*AW +: AW]  = a;
        bus0.wdata[ch*DW +: DW] = d;
        bus0.be[ch*2 +: 2]      = b;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus0.gnt[ch]) begin
                seen = 1'b1;
                gcyc = cyc;
                check("gnt_onehot", 32'(bus0.gnt), 32'(4'b1 << ch));
            end
        end
        check("gnt_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        bus0.req[ch] = 1'b0;
    endtask

    task automatic drain();
        exp_t e;
        int   n;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = 0;
            while (rv_n <= rd_idx && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("rvalid_seen", 32'(rv_n > rd_idx), 32'd1);
            if (rv_n > rd_idx) begin
                check("rvalid_ch", 32'(rv_ch[rd_idx]), 32'(4'b1 << e.ch));
                check("rvalid_latency", 32'(rv_cyc[rd_idx]), 32'(e.due));
                if (e.chk) check("rdata", 32'(rv_dat[rd_idx]), 32'(e.data));
                rd_idx++;
            end
        end
    endtask

    initial begin
        int g;
        int rv_before;
        int we_start;
        int oe_start;
        int got;
        int idx;
        int gch [6];
        int gcy [6];
        bit seen;
        int rvc;
        logic [15:0] rvd;

        bus0.req = '0; bus0.we = '0; bus0.addr = '0; bus0.wdata = '0; bus0.be = '0;
        bus1.req = '0; bus1.we = '0; bus1.addr = '0; bus1.wdata = '0; bus1.be = '0;

        // Reset values
        probe = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(bus0.gnt), 32'd0);
        check("rst_rvalid", 32'(bus0.rvalid), 32'd0);
        check("rst_rdata", 32'(bus0.rdata), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_addr", 32'(a0), 32'd0);
        check("rst_ctrl", 32'({ce0, oe0, we0, ub0, lb0}), 32'(5'b11111));
        check("rst_dq_hiz", 32'(dq0), 32'h0000);
        @(posedge clk); #1;
        probe = 1'b0;
        rst   = 1'b0;

        // Single write then read on ch2
        we_start = we0_low;
        issue(2, 1'b1, 20'h00123, 16'hBEEF, 2'b11, g);
        @(negedge clk);
        check("wr1_ctrl", 32'({ce0, oe0, we0, ub0, lb0}), 32'(5'b01000));
        check("wr1_dq", 32'(dq0), 32'hBEEF);
        check("wr1_addr", 32'(a0), 32'h00123);
        check("wr1_busy", 32'(bus0.busy), 32'd1);
        @(negedge clk);
        check("wr2_ctrl", 32'({ce0, oe0, we0, ub0, lb0}), 32'(5'b01100));
        check("wr2_dq", 32'(dq0), 32'hBEEF);
        @(negedge clk);
        check("wr_done_ctrl", 32'({ce0, oe0, we0, ub0, lb0}), 32'(5'b11111));
        check("wr_done_busy", 32'(bus0.busy), 32'd0);
        check("we_low_cycles", 32'(we0_low - we_start), 32'd1);
        issue(2, 1'b0, 20'h00123, 16'h0000, 2'b11, g);
        sb.push_back('{ch: 2, data: 16'hBEEF, chk: 1'b1, due: g + 3});
        drain();

        // Byte-enable merge on ch0
        issue(0, 1'b1, 20'h00040, 16'hBEEF, 2'b11, g);
        issue(0, 1'b1, 20'h00040, 16'h1234, 2'b01, g);
        @(negedge clk);
        check("be_wr1_ub", 32'(ub0), 32'd1);
        check("be_wr1_lb", 32'(lb0), 32'd0);
        check("be_wr1_we", 32'(we0), 32'd0);
        issue(0, 1'b0, 20'h00040, 16'h0000, 2'b11, g);
        sb.push_back('{ch: 0, data: 16'hBE34, chk: 1'b1, due: g + 3});
        drain();

        // Back-to-back: read on ch1, write on ch3 granted in the rvalid cycle
        @(posedge clk); #1;
        bus0.req[1] = 1'b1; bus0.we[1] = 1'b0;
        bus0.addr[1*AW +: AW] = 20'h00123; bus0.be[1*2 +: 2] = 2'b11;
        seen = 1'b0; g = -1;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus0.gnt[1]) begin seen = 1'b1; g = cyc; end
        end
        check("b2b_gnt1_seen", 32'(seen), 32'd1);
        sb.push_back('{ch: 1, data: 16'hBEEF, chk: 1'b1, due: g + 3});
        @(posedge clk); #1;
        bus0.req[1] = 1'b0;
        bus0.req[3] = 1'b1; bus0.we[3] = 1'b1;
        bus0.addr[3*AW +: AW] = 20'h00050; bus0.wdata[3*DW +: DW] = 16'h5A5A;
        bus0.be[3*2 +: 2] = 2'b11;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        probe = 1'b1;
        @(negedge clk);
        check("b2b_gnt3", 32'(bus0.gnt), 32'(4'b1000));
        check("b2b_rvalid1", 32'(bus0.rvalid), 32'(4'b0010));
        check("b2b_idle_dq_hiz", 32'(dq0), 32'h0000);
        check("b2b_grant_cycle", 32'(cyc), 32'(g + 3));
        @(posedge clk); #1;
        probe = 1'b0;
        bus0.req[3] = 1'b0;
        @(negedge clk);
        check("b2b_wr1_dq", 32'(dq0), 32'h5A5A);
        check("b2b_wr1_we", 32'(we0), 32'd0);
        @(negedge clk);
        check("b2b_wr2_dq", 32'(dq0), 32'h5A5A);
        check("b2b_wr2_we", 32'(we0), 32'd1);
        @(posedge clk); #1;
        probe = 1'b1;
        @(negedge clk);
        check("b2b_after_dq_hiz", 32'(dq0), 32'h0000);
        check("b2b_after_ce", 32'(ce0), 32'd1);
        @(posedge clk); #1;
        probe = 1'b0;
        drain();

        // Reset in the first RD cycle
        issue(2, 1'b0, 20'h00123, 16'h0000, 2'b11, g);
        rst = 1'b1;
        rv_before = rv_n;
        @(posedge clk); #1;
        @(negedge clk);
        check("mrst_ctrl", 32'({ce0, oe0, we0, ub0, lb0}), 32'(5'b11111));
        check("mrst_busy", 32'(bus0.busy), 32'd0);
        check("mrst_addr", 32'(a0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mrst_no_rvalid", 32'(rv_n), 32'(rv_before));

        // Arbitration with every channel requesting reads continuously
        @(posedge clk); #1;
        for (int i = 0; i < NCH; i++) begin
            bus0.we[i] = 1'b0;
            bus0.addr[i*AW +: AW] = 20'(i);
            bus0.be[i*2 +: 2] = 2'b11;
        end
        bus0.req = 4'b1111;
        got = 0;
        for (int n = 0; n < 60 && got < 6; n++) begin
            @(negedge clk);
            if (bus0.gnt != 4'b0) begin
                check("rr_onehot", 32'($onehot(bus0.gnt)), 32'd1);
                idx = 0;
                for (int k = 0; k < NCH; k++) if (bus0.gnt[k]) idx = k;
                gch[got] = idx;
                gcy[got] = cyc;
                sb.push_back('{ch: idx, data: 16'h0000, chk: 1'b0, due: cyc + 3});
                got++;
            end
        end
        @(posedge clk); #1;
        bus0.req = 4'b0000;
        check("rr_count", 32'(got), 32'd6);
        for (int i = 0; i < got; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            check("arb_order", 32'(gch[i]), 32'd0);
`else
            check("arb_order", 32'(gch[i]), 32'(i % NCH));
`endif
            if (i > 0) check("arb_spacing", 32'(gcy[i] - gcy[i-1]), 32'd3);
        end
        drain();

        // RD_WAIT=3 instance
        oe_start = oe1_low;
        @(posedge clk); #1;
        bus1.req[0] = 1'b1; bus1.we[0] = 1'b0;
        bus1.addr[0 +: AW] = 20'h00007; bus1.be[0 +: 2] = 2'b11;
        seen = 1'b0; g = -1;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus1.gnt[0]) begin seen = 1'b1; g = cyc; end
        end
        check("rw3_gnt_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        bus1.req[0] = 1'b0;
        seen = 1'b0; rvc = -1; rvd = '0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus1.rvalid != 4'b0) begin
                seen = 1'b1; rvc = cyc; rvd = bus1.rdata;
                check("rw3_rvalid_ch", 32'(bus1.rvalid), 32'(4'b0001));
            end
        end
        check("rw3_rvalid_seen", 32'(seen), 32'd1);
        check("rw3_latency", 32'(rvc - g), 32'd5);
        check("rw3_rdata", 32'(rvd), 32'hC0DE);
        check("rw3_oe_low_cycles", 32'(oe1_low - oe_start), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
